// File: rtl/crossbar_pipe.sv
// Output-buffered crossbar: one 2-entry FIFO per output, fed from the input picked by tab_out.
// Define CROSSBAR_STATS_EN to add the per-output saturating flit_cnt counters.
module crossbar_pipe #(
    parameter int NPORT    = 5,
    parameter int TAM_FLIT = 16,
    parameter int SEL_W    = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          data_av,
    input  logic [NPORT*TAM_FLIT-1:0] data_in,
    input  logic [NPORT-1:0]          free,
    input  logic [NPORT*SEL_W-1:0]    tab_out,
    input  logic [NPORT-1:0]          credit_i,
    output logic [NPORT-1:0]          data_ack,
    output logic [NPORT-1:0]          tx,
    output logic [NPORT*TAM_FLIT-1:0] data_out
`ifdef CROSSBAR_STATS_EN
    ,
    output logic [NPORT*16-1:0]       flit_cnt
`endif
);

    logic [1:0]          r_count  [NPORT];
    logic [NPORT-1:0]    r_rd_ptr;
    logic [NPORT-1:0]    r_wr_ptr;
    logic [TAM_FLIT-1:0] r_mem    [NPORT][2];

    logic [NPORT-1:0]    w_push;
    logic [NPORT-1:0]    w_pop;
    logic [TAM_FLIT-1:0] w_push_data [NPORT];

    // Lower-index outputs claim a source first, so a flit is pushed into at most one FIFO.
    always_comb begin : arbitrate
        logic [NPORT-1:0] taken;
        // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latch).
        taken    = '0;
        w_push   = '0;
        data_ack = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_push_data[o] = '0;
            for (int s = 0; s < NPORT; s++) begin
                if (int'(tab_out[o*SEL_W +: SEL_W]) == s) begin
                    w_push_data[o] = data_in[s*TAM_FLIT +: TAM_FLIT];
                    // NOTE: 'taken' is a blocking temporary; later iterations must see earlier claims.
                    if (reset && !free[o] && data_av[s] && (r_count[o] != 2'd2) && !taken[s]) begin
                        w_push[o]   = 1'b1;
                        taken[s]    = 1'b1;
                        data_ack[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int o = 0; o < NPORT; o++) begin
            tx[o]    = (r_count[o] != 2'd0);
            w_pop[o] = tx[o] && credit_i[o];
            if (tx[o]) begin
                data_out[o*TAM_FLIT +: TAM_FLIT] = r_mem[o][r_rd_ptr[o]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int o = 0; o < NPORT; o++) begin
                r_count[o] <= 2'd0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (w_push[o]) begin
                    r_wr_ptr[o] <= ~r_wr_ptr[o];
                end
                if (w_pop[o]) begin
                    r_rd_ptr[o] <= ~r_rd_ptr[o];
                end
                case ({w_push[o], w_pop[o]})
                    2'b10:   r_count[o] <= r_count[o] + 2'd1;
                    2'b01:   r_count[o] <= r_count[o] - 2'd1;
                    default: r_count[o] <= r_count[o];
                endcase
            end
        end
    end

    // NOTE: storage has no reset; an empty FIFO masks it to zero on data_out.
    always_ff @(posedge clock) begin
        for (int o = 0; o < NPORT; o++) begin
            if (w_push[o]) begin
                r_mem[o][r_wr_ptr[o]] <= w_push_data[o];
            end
        end
    end

`ifdef CROSSBAR_STATS_EN
    logic [15:0] r_flit_cnt [NPORT];

    always_ff @(posedge clock) begin
        for (int o = 0; o < NPORT; o++) begin
            if (!reset) begin
                r_flit_cnt[o] <= 16'd0;
            end else if (w_pop[o] && (r_flit_cnt[o] != 16'hFFFF)) begin
                r_flit_cnt[o] <= r_flit_cnt[o] + 16'd1;
            end
        end
    end

    always_comb begin
        flit_cnt = '0;
        for (int o = 0; o < NPORT; o++) begin
            flit_cnt[o*16 +: 16] = r_flit_cnt[o];
        end
    end
`else
    // Statistics disabled: no counters and no flit_cnt port.
`endif

endmodule

// File: tb/tb_crossbar_pipe.sv
// Self-checking bench for crossbar_pipe: directed scenarios plus random traffic against a queue model.
// Define CROSSBAR_STATS_EN to also exercise the flit_cnt counters.
module tb_crossbar_pipe;

    localparam int NPORT = 5;
    localparam int TAM   = 16;
    localparam int SEL_W = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NPORT-1:0]       data_av;
    logic [NPORT*TAM-1:0]   data_in;
    logic [NPORT-1:0]       free;
    logic [NPORT*SEL_W-1:0] tab_out;
    logic [NPORT-1:0]       credit_i;
    logic [NPORT-1:0]       data_ack;
    logic [NPORT-1:0]       tx;
    logic [NPORT*TAM-1:0]   data_out;
`ifdef CROSSBAR_STATS_EN
    logic [NPORT*16-1:0]    flit_cnt;
`endif

    crossbar_pipe #(.NPORT(NPORT), .TAM_FLIT(TAM), .SEL_W(SEL_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_av  (data_av),
        .data_in  (data_in),
        .free     (free),
        .tab_out  (tab_out),
        .credit_i (credit_i),
        .data_ack (data_ack),
        .tx       (tx),
        .data_out (data_out)
`ifdef CROSSBAR_STATS_EN
        ,
        .flit_cnt (flit_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one bounded queue of flits per output, plus a pop counter per output.
    logic [TAM-1:0]   mq [NPORT][$];
    int unsigned      mcnt [NPORT];
    logic [NPORT-1:0] last_tx;
    logic [NPORT-1:0] last_ack;
    logic [NPORT*TAM-1:0] last_dout;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int o, input int s);
        tab_out[o*SEL_W +: SEL_W] = SEL_W'(s);
    endtask

    task automatic set_din(input int p, input logic [TAM-1:0] v);
        data_in[p*TAM +: TAM] = v;
    endtask

    task automatic model_clear();
        for (int o = 0; o < NPORT; o++) begin
            mq[o].delete();
            mcnt[o] = 0;
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [NPORT-1:0]     exp_ack;
        logic [NPORT-1:0]     exp_tx;
        logic [NPORT*TAM-1:0] exp_dout;
        logic [NPORT-1:0]     push;
        int                   src [NPORT];
        #2;
        exp_ack  = '0;
        exp_tx   = '0;
        exp_dout = '0;
        push     = '0;
        for (int o = 0; o < NPORT; o++) begin
            src[o] = int'(tab_out[o*SEL_W +: SEL_W]);
            if (mq[o].size() > 0) begin
                exp_tx[o] = 1'b1;
                exp_dout[o*TAM +: TAM] = mq[o][0];
            end
            if (reset && !free[o] && src[o] < NPORT && mq[o].size() < 2) begin
                if (data_av[src[o]] && !exp_ack[src[o]]) begin
                    push[o] = 1'b1;
                    exp_ack[src[o]] = 1'b1;
                end
            end
        end
        check("data_ack", 128'(data_ack), 128'(exp_ack));
        check("tx", 128'(tx), 128'(exp_tx));
        check("data_out", 128'(data_out), 128'(exp_dout));
`ifdef CROSSBAR_STATS_EN
        for (int o = 0; o < NPORT; o++) begin
            check("flit_cnt", 128'(flit_cnt[o*16 +: 16]), 128'(mcnt[o]));
        end
`endif
        last_tx   = tx;
        last_ack  = data_ack;
        last_dout = data_out;
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (mq[o].size() > 0 && credit_i[o]) begin
                    void'(mq[o].pop_front());
                    if (mcnt[o] < 32'hFFFF) mcnt[o]++;
                end
                if (push[o]) mq[o].push_back(data_in[src[o]*TAM +: TAM]);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        int n_tx;
        int n_ack;
        logic [TAM-1:0] nxt;

        // Reset held with every input requesting and every output allocated.
        reset    = 1'b0;
        data_av  = 5'b11111;
        free     = 5'b00000;
        credit_i = 5'b00000;
        for (int o = 0; o < NPORT; o++) begin
            set_sel(o, o);
            set_din(o, TAM'(16'h1000 + o));
        end
        model_clear();
        @(posedge clock);
        @(negedge clock);
        repeat (2) cycle();
        check("rst_ack", 128'(last_ack), 128'(0));

        // Release: acks in the same cycle, tx one cycle later, then full FIFOs refuse.
        reset = 1'b1;
        cycle();
        check("first_ack", 128'(last_ack), 128'(5'b11111));
        check("first_tx_low", 128'(last_tx), 128'(0));
        cycle();
        check("tx_rise", 128'(last_tx), 128'(5'b11111));
        repeat (3) cycle();

        // Reset with both entries of every FIFO full: everything discarded.
        reset = 1'b0;
        cycle();
        reset   = 1'b1;
        data_av = 5'b00000;
        repeat (2) cycle();
        check("no_stale_tx", 128'(last_tx), 128'(0));

        // EAST fed from LOCAL with steady credit: 8 flits in 8 consecutive cycles.
        free     = 5'b11110;
        set_sel(0, 4);
        credit_i = 5'b00001;
        n_tx     = 0;
        for (int k = 0; k < 12; k++) begin
            data_av = (k < 8) ? 5'b10000 : 5'b00000;
            set_din(4, TAM'(16'hA5A5 + k));
            cycle();
            if (last_tx[0]) n_tx++;
            if (k == 1) check("east_first", 128'(last_dout[15:0]), 128'(16'hA5A5));
        end
        check("east_flits", 128'(n_tx), 128'(8));

        // No credit: two acked, third held; after credit the third waits for room.
        credit_i = 5'b00000;
        data_av  = 5'b10000;
        nxt      = 16'h3000;
        set_din(4, nxt);
        n_ack    = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (last_ack[4]) begin
                n_ack++;
                nxt = nxt + 16'd1;
                set_din(4, nxt);
            end
        end
        check("held_acks", 128'(n_ack), 128'(2));
        credit_i = 5'b00001;
        cycle();
        check("full_refuse", 128'(last_ack[4]), 128'(0));
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (last_ack[4]) begin
                nxt = nxt + 16'd1;
                set_din(4, nxt);
            end
        end
        data_av = 5'b00000;
        repeat (3) cycle();

        // Outputs 1 and 3 both select input 0: only output 1 takes it.
        free     = 5'b10101;
        set_sel(1, 0);
        set_sel(3, 0);
        credit_i = 5'b11111;
        data_av  = 5'b00001;
        n_ack    = 0;
        for (int k = 0; k < 6; k++) begin
            set_din(0, TAM'(16'h5000 + k));
            cycle();
            if (last_ack[0]) n_ack++;
            check("tx3_idle", 128'(last_tx[3]), 128'(0));
        end
        check("shared_acks", 128'(n_ack), 128'(6));
        data_av = 5'b00000;
        repeat (3) cycle();

        // Out-of-range select is no source.
        free    = 5'b11011;
        set_sel(2, 7);
        data_av = 5'b11111;
        repeat (3) cycle();
        check("sel7_ack", 128'(last_ack), 128'(0));
        check("sel7_tx", 128'(last_tx[2]), 128'(0));

        // Stored flits still drain once the output is released.
        free     = 5'b11110;
        set_sel(0, 2);
        credit_i = 5'b00000;
        repeat (3) cycle();
        free     = 5'b11111;
        credit_i = 5'b00001;
        cycle();
        check("drain_tx", 128'(last_tx[0]), 128'(1));
        repeat (3) cycle();

        // Random traffic with occasional reset.
        for (int k = 0; k < 600; k++) begin
            reset    = ($urandom_range(0, 40) != 0);
            data_av  = NPORT'($urandom);
            free     = NPORT'($urandom);
            credit_i = NPORT'($urandom);
            tab_out  = (NPORT*SEL_W)'($urandom);
            for (int p = 0; p < NPORT; p++) set_din(p, TAM'($urandom));
            cycle();
        end

`ifdef CROSSBAR_STATS_EN
        // Saturation of output 0's counter; the others stay at zero.
        reset = 1'b0;
        cycle();
        reset    = 1'b1;
        free     = 5'b11110;
        set_sel(0, 0);
        data_av  = 5'b00001;
        credit_i = 5'b00001;
        repeat (70010) cycle();
        check("cnt0_sat", 128'(flit_cnt[15:0]), 128'(16'hFFFF));
        check("cnt_others", 128'(flit_cnt[NPORT*16-1:16]), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crossbar_pipe.md
CROSSBAR_PIPE -- requirements
Module: crossbar_pipe

Interface
REQ-001 SHALL have parameter NPORT, default 5, meaning number of router ports (EAST=0 .. LOCAL=4 at default).
REQ-002 SHALL have parameter TAM_FLIT, default 16, meaning flit width in bits.
REQ-003 SHALL have parameter SEL_W, default 3, meaning width of each per-port select field; SEL_W >= clog2(NPORT).
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 SHALL have port clock, input, 1, meaning rising-edge clock.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port data_av, input, NPORT, meaning input port i presents a valid flit.
REQ-008 SHALL have port data_in, input, NPORT*TAM_FLIT, meaning flattened input flits; port i is bits [i*TAM_FLIT +: TAM_FLIT].
REQ-009 SHALL have port free, input, NPORT, meaning output o is unallocated when 1 and connected when 0.
REQ-010 SHALL have port tab_out, input, NPORT*SEL_W, meaning flattened source-input select for each output.
REQ-011 SHALL have port credit_i, input, NPORT, meaning downstream of output o consumes the presented flit this cycle.
REQ-012 SHALL have port data_ack, output, NPORT, meaning input i's flit is accepted this cycle.
REQ-013 SHALL have port tx, output, NPORT, meaning output o presents a valid flit.
REQ-014 SHALL have port data_out, output, NPORT*TAM_FLIT, meaning flattened output flits.

Function
REQ-015 SHALL contain one 2-entry in-order FIFO per output o, with count_o in 0..2.
REQ-016 SHALL accept (push) into FIFO o when free[o]=0, tab_out[o]=s<NPORT, data_av[s]=1, count_o<2, and no lower-index output accepts from s in the same cycle.
REQ-017 SHALL drive data_ack[s] combinationally high in exactly the cycle its flit is pushed, and low otherwise.
REQ-018 SHALL push a given input flit into at most one output FIFO per cycle; when several outputs select the same source, only the lowest-index eligible output accepts.
REQ-019 SHALL treat tab_out[o] >= NPORT as no source: no push and no ack.
REQ-020 SHALL drive tx[o]=1 iff count_o>0, and data_out[o]=head entry, or all zeros when empty.
REQ-021 SHALL pop the head of FIFO o on a rising edge when tx[o]=1 and credit_i[o]=1; credit_i[o] while empty SHALL be ignored.
REQ-022 SHALL add exactly one cycle of latency: a flit pushed at edge k SHALL appear on tx/data_out in the cycle after edge k when the FIFO was empty.
REQ-023 SHALL sustain one flit per cycle per output with continuous credit_i (push and pop in the same cycle, count unchanged).
REQ-024 SHALL not let credit_i[o] gate data_ack combinationally: a full FIFO (count=2) SHALL refuse pushes even when popping that cycle.
REQ-025 SHALL keep draining already-stored flits after free[o] returns to 1; only new pushes stop.
REQ-026 SHALL preserve flit order per output and never duplicate or drop an acked flit.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, clear all counts and pointers, drive tx=0, data_out=0, and data_ack=0, and discard stored flits, including in-flight ones.
REQ-028 SHALL hold data_ack=0 while reset=0 regardless of the other inputs.

Configuration
REQ-029 SHALL, when macro CROSSBAR_STATS_EN is defined, add output flit_cnt (NPORT*16 bits), one 16-bit counter per output that increments on each pop, saturates at 0xFFFF, and clears on reset.
REQ-030 SHALL, when CROSSBAR_STATS_EN is undefined, omit the flit_cnt port and its counters entirely, with behaviour otherwise identical.

Verification
REQ-031 SHALL cover: reset low with data_av=5'b11111 and free=0 -> data_ack=0, tx=0; after release, the first acks arrive in the same cycle and tx rises one cycle later.
REQ-032 SHALL cover: free[EAST]=0, tab_out[EAST]=LOCAL, data_in[LOCAL]=0xA5A5, credit_i=1 steady -> tx[EAST]=1 with 0xA5A5 next cycle; 8 flits pass in 8 consecutive cycles.
REQ-033 SHALL cover: credit_i[EAST]=0 with 3 flits offered -> 2 acked, third held (data_ack=0); after credit_i=1, flits exit in order and the third is acked only once count<2.
REQ-034 SHALL cover: outputs 1 and 3 both select input 0 -> only output 1 pushes, data_ack[0] pulses once per flit, and tx[3] stays 0.
REQ-035 SHALL cover: tab_out[2]=7 with free[2]=0 -> no ack and tx[2]=0; reset asserted with both FIFOs full -> tx=0 next cycle and no stale flit after release.
REQ-036 SHALL cover, with CROSSBAR_STATS_EN defined: 70000 pops on output 0 -> flit_cnt[0] reads 0xFFFF, and other counters are unaffected.
